// File: rtl/ps2_key_receiver.sv
// PS/2 keyboard receiver: synchronises the raw bus, deframes bytes and
// decodes make / break (F0) / extended (E0) sequences into key state.
module ps2_key_receiver #(
  parameter int TIMEOUT_CYCLES = 10000
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       PS2_CLK,
  input  logic       PS2_DAT,
  output logic [7:0] last_key_received,
  output logic       key_extended,
  output logic       key_held,
  output logic       key_strobe,
  output logic       frame_error
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t          state;
  logic [2:0]      clk_sh;
  logic [1:0]      dat_sh;
  logic [2:0]      bit_cnt;
  logic [7:0]      shreg;
  logic            par_bit;
  logic [CW-1:0]   to_cnt;
  logic            ext_pending;
  logic            brk_pending;
  logic            fall;
  logic            dat_bit;
  logic            frame_ok;

  assign fall     = clk_sh[2] & ~clk_sh[1];
  assign dat_bit  = dat_sh[1];
  assign frame_ok = dat_bit & (^{shreg, par_bit});

  // Two-flop synchronisers plus one history flop for fall detection
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      clk_sh <= 3'b111;
      dat_sh <= 2'b11;
    end else begin
      clk_sh <= {clk_sh[1:0], PS2_CLK};
      dat_sh <= {dat_sh[0], PS2_DAT};
    end
  end

  // Frame FSM with inter-bit timeout and byte decode on the stop bit
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state             <= IDLE;
      bit_cnt           <= '0;
      shreg             <= '0;
      par_bit           <= 1'b0;
      to_cnt            <= '0;
      ext_pending       <= 1'b0;
      brk_pending       <= 1'b0;
      last_key_received <= '0;
      key_extended      <= 1'b0;
      key_held          <= 1'b0;
      key_strobe        <= 1'b0;
      frame_error       <= 1'b0;
    end else begin
      key_strobe  <= 1'b0;
      frame_error <= 1'b0;
      if (state == IDLE) begin
        to_cnt <= '0;
        if (fall && !dat_bit) begin
          state   <= DATA;
          bit_cnt <= '0;
        end
      end else if (fall) begin
        to_cnt <= '0;
        case (state)
          DATA: begin
            shreg   <= {dat_bit, shreg[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) state <= PARITY;
          end
          PARITY: begin
            par_bit <= dat_bit;
            state   <= STOP;
          end
          default: begin
            state <= IDLE;
            if (!frame_ok) begin
              frame_error <= 1'b1;
            end else if (shreg == 8'hE0) begin
              ext_pending <= 1'b1;
            end else if (shreg == 8'hF0) begin
              brk_pending <= 1'b1;
            end else if (brk_pending) begin
              if (shreg == last_key_received &&
                  ext_pending == key_extended)
                key_held <= 1'b0;
              ext_pending <= 1'b0;
              brk_pending <= 1'b0;
            end else begin
              last_key_received <= shreg;
              key_extended      <= ext_pending;
              key_held          <= 1'b1;
              key_strobe        <= 1'b1;
              ext_pending       <= 1'b0;
              brk_pending       <= 1'b0;
            end
          end
        endcase
      end else if (to_cnt == TO_LAST) begin
        state       <= IDLE;
        to_cnt      <= '0;
        frame_error <= 1'b1;
      end else begin
        to_cnt <= to_cnt + CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_ps2_key_receiver.sv
// Self-checking bench for ps2_key_receiver: directed scenarios plus
// randomised key sequences against a byte-level key-state model.
`timescale 1ns/1ps
module tb_ps2_key_receiver;

  localparam int TO = 200;
  localparam int H  = 10;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_dat = 1'b1;
  logic [7:0] last_key_received;
  logic       key_extended;
  logic       key_held;
  logic       key_strobe;
  logic       frame_error;

  int n_checks = 0;
  int n_errors = 0;
  int n_strobe = 0;
  int n_err = 0;
  int n_both = 0;

  logic [7:0] exp_key;
  logic       exp_ext;
  logic       exp_held;
  logic       pend_e;
  logic       pend_b;
  int         exp_strobes;

  ps2_key_receiver #(.TIMEOUT_CYCLES(TO)) dut (
    .clock(clk),
    .resetn(resetn),
    .PS2_CLK(ps2_clk),
    .PS2_DAT(ps2_dat),
    .last_key_received(last_key_received),
    .key_extended(key_extended),
    .key_held(key_held),
    .key_strobe(key_strobe),
    .frame_error(frame_error)
  );

  always #10 clk = ~clk;

  // Pulse counters sampled on the active edge
  always @(posedge clk) begin
    if (key_strobe === 1'b1) n_strobe <= n_strobe + 1;
    if (frame_error === 1'b1) n_err <= n_err + 1;
    if (key_strobe === 1'b1 && frame_error === 1'b1)
      n_both <= n_both + 1;
  end

  function automatic logic [10:0] mk_frame(
    input logic [7:0] c, input bit bad_par, input bit bad_stop);
    logic p;
    p = ~(^c);
    if (bad_par) p = ~p;
    return {~bad_stop, p, c, 1'b0};
  endfunction

  task automatic model_reset();
    exp_key = 8'h00; exp_ext = 0; exp_held = 0;
    pend_e = 0; pend_b = 0; exp_strobes = 0;
  endtask

  task automatic model_byte(input logic [7:0] b);
    if (b == 8'hE0) pend_e = 1;
    else if (b == 8'hF0) pend_b = 1;
    else if (pend_b) begin
      if (b == exp_key && pend_e == exp_ext) exp_held = 0;
      pend_e = 0; pend_b = 0;
    end else begin
      exp_key = b; exp_ext = pend_e; exp_held = 1;
      exp_strobes++;
      pend_e = 0; pend_b = 0;
    end
  endtask

  task automatic wait_neg(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(
    input logic [10:0] f, input int nbits, input bit chk);
    for (int i = 0; i < nbits; i++) begin
      @(negedge clk);
      ps2_dat = f[i];
      wait_neg(H);
      ps2_clk = 1'b0;
      if (chk && i == 10) begin
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (key_strobe !== 1'b0) begin
          n_errors++;
          $display("FAIL strobe_early: got %b want 0", key_strobe);
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (key_strobe !== 1'b1) begin
          n_errors++;
          $display("FAIL strobe_latency: got %b want 1", key_strobe);
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (key_strobe !== 1'b0) begin
          n_errors++;
          $display("FAIL strobe_width: got %b want 0", key_strobe);
        end
        wait_neg(H - 3);
      end else begin
        wait_neg(H);
      end
      ps2_clk = 1'b1;
    end
    ps2_dat = 1'b1;
    wait_neg(2 * H);
  endtask

  task automatic send_byte(input logic [7:0] b);
    send_frame(mk_frame(b, 0, 0), 11, 0);
    model_byte(b);
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    model_reset();
    wait_neg(5);
    n_checks++;
    if ({last_key_received, key_extended, key_held,
         key_strobe, frame_error} !== 12'h000) begin
      n_errors++;
      $display("FAIL reset_outputs: got %h %b%b%b%b want 00 0000",
        last_key_received, key_extended, key_held,
        key_strobe, frame_error);
    end
    resetn = 1'b1;
    wait_neg(5);
  endtask

  task automatic test_make();
    int s0, e0;
    s0 = n_strobe; e0 = n_err;
    send_frame(mk_frame(8'h1D, 0, 0), 11, 1);
    model_byte(8'h1D);
    n_checks++;
    if ({last_key_received, key_extended, key_held} !== {8'h1D, 2'b01}) begin
      n_errors++;
      $display("FAIL make_1d: got %h %b %b want 1d 0 1",
        last_key_received, key_extended, key_held);
    end
    n_checks++;
    if (n_strobe - s0 !== 1 || n_err - e0 !== 0) begin
      n_errors++;
      $display("FAIL make_pulses: strobes %0d errs %0d want 1 0",
        n_strobe - s0, n_err - e0);
    end
  endtask

  task automatic test_break();
    int s0;
    s0 = n_strobe;
    send_byte(8'hF0);
    send_byte(8'h1D);
    n_checks++;
    if ({last_key_received, key_extended, key_held} !== {8'h1D, 2'b00} ||
        n_strobe != s0) begin
      n_errors++;
      $display("FAIL break_1d: got %h %b %b strobes %0d want 1d 0 0 0",
        last_key_received, key_extended, key_held, n_strobe - s0);
    end
  endtask

  task automatic test_extended();
    int s0;
    s0 = n_strobe;
    send_byte(8'hE0);
    send_byte(8'h75);
    n_checks++;
    if ({last_key_received, key_extended, key_held} !== {8'h75, 2'b11} ||
        n_strobe - s0 != 1) begin
      n_errors++;
      $display("FAIL ext_make: got %h %b %b strobes %0d want 75 1 1 1",
        last_key_received, key_extended, key_held, n_strobe - s0);
    end
    send_byte(8'hE0);
    send_byte(8'hF0);
    send_byte(8'h75);
    n_checks++;
    if ({last_key_received, key_extended, key_held} !== {8'h75, 2'b10}) begin
      n_errors++;
      $display("FAIL ext_break: got %h %b %b want 75 1 0",
        last_key_received, key_extended, key_held);
    end
    send_byte(8'hE0);
    send_byte(8'h75);
    send_byte(8'hF0);
    send_byte(8'h75);
    n_checks++;
    if ({last_key_received, key_extended, key_held} !== {8'h75, 2'b11}) begin
      n_errors++;
      $display("FAIL ext_break_noe0: got %h %b %b want 75 1 1",
        last_key_received, key_extended, key_held);
    end
  endtask

  task automatic test_non_current();
    int s0;
    s0 = n_strobe;
    send_byte(8'h1D);
    send_byte(8'h1B);
    send_byte(8'hF0);
    send_byte(8'h1D);
    n_checks++;
    if ({last_key_received, key_extended, key_held} !== {8'h1B, 2'b01} ||
        n_strobe - s0 != 2) begin
      n_errors++;
      $display("FAIL non_current: got %h %b %b strobes %0d want 1b 0 1 2",
        last_key_received, key_extended, key_held, n_strobe - s0);
    end
  endtask

  task automatic test_bad_frames();
    int s0, e0;
    for (int k = 0; k < 2; k++) begin
      s0 = n_strobe; e0 = n_err;
      send_frame(mk_frame(8'h1C, k == 0, k == 1), 11, 0);
      n_checks++;
      if ({last_key_received, key_extended, key_held} !== {8'h1B, 2'b01} ||
          n_strobe != s0 || n_err - e0 != 1) begin
        n_errors++;
        $display("FAIL bad_frame%0d: got %h %b %b s%0d e%0d want 1b 0 1 s0 e1",
          k, last_key_received, key_extended, key_held,
          n_strobe - s0, n_err - e0);
      end
    end
  endtask

  task automatic test_timeout();
    int k, e0, s0;
    e0 = n_err;
    send_frame(mk_frame(8'h1B, 0, 0), 5, 0);
    k = 3 * H;
    while (frame_error !== 1'b1 && k < TO + 60) begin
      @(posedge clk);
      #1;
      k++;
    end
    n_checks++;
    if (k < TO || k > TO + 4) begin
      n_errors++;
      $display("FAIL timeout_delay: got %0d clocks want %0d..%0d",
        k, TO, TO + 4);
    end
    wait_neg(5);
    n_checks++;
    if (n_err - e0 != 1 ||
        {last_key_received, key_extended, key_held} !== {8'h1B, 2'b01}) begin
      n_errors++;
      $display("FAIL timeout_pulse: errs %0d key %h want 1 1b",
        n_err - e0, last_key_received);
    end
    s0 = n_strobe;
    send_byte(8'h1B);
    n_checks++;
    if ({last_key_received, key_extended, key_held} !== {8'h1B, 2'b01} ||
        n_strobe - s0 != 1) begin
      n_errors++;
      $display("FAIL timeout_recover: got %h strobes %0d want 1b 1",
        last_key_received, n_strobe - s0);
    end
  endtask

  task automatic test_reset_mid();
    int s0, e0;
    send_frame(mk_frame(8'h44, 0, 0), 5, 0);
    @(negedge clk);
    resetn = 1'b0;
    model_reset();
    s0 = n_strobe; e0 = n_err;
    #1;
    n_checks++;
    if ({last_key_received, key_extended, key_held,
         key_strobe, frame_error} !== 12'h000) begin
      n_errors++;
      $display("FAIL reset_mid: got %h %b%b%b%b want 00 0000",
        last_key_received, key_extended, key_held,
        key_strobe, frame_error);
    end
    wait_neg(4);
    resetn = 1'b1;
    wait_neg(TO + 20);
    send_byte(8'h23);
    n_checks++;
    if ({last_key_received, key_extended, key_held} !== {8'h23, 2'b01} ||
        n_strobe - s0 != 1 || n_err != e0) begin
      n_errors++;
      $display("FAIL reset_recover: got %h s%0d e%0d want 23 s1 e0",
        last_key_received, n_strobe - s0, n_err - e0);
    end
  endtask

  task automatic test_random();
    int s0, m0, act;
    logic [7:0] c;
    for (int it = 0; it < 40; it++) begin
      s0 = n_strobe; m0 = exp_strobes;
      act = $urandom_range(0, 3);
      do c = 8'($urandom_range(1, 255));
      while (c == 8'hE0 || c == 8'hF0);
      if (act == 2) c = exp_key;
      if ($urandom_range(0, 1) == 1) send_byte(8'hE0);
      if (act >= 2) send_byte(8'hF0);
      send_byte(c);
      n_checks++;
      if ({last_key_received, key_extended, key_held} !==
          {exp_key, exp_ext, exp_held} ||
          n_strobe - s0 != exp_strobes - m0) begin
        n_errors++;
        $display("FAIL random_%0d: got %h %b %b s%0d want %h %b %b s%0d",
          it, last_key_received, key_extended, key_held, n_strobe - s0,
          exp_key, exp_ext, exp_held, exp_strobes - m0);
      end
    end
  endtask

  initial begin
    test_reset();
    test_make();
    test_break();
    test_extended();
    test_non_current();
    test_bad_frames();
    test_timeout();
    test_reset_mid();
    test_random();
    n_checks++;
    if (n_both != 0) begin
      n_errors++;
      $display("FAIL overlap: got %0d cycles want 0", n_both);
    end
    $display("Simulation finished: %0d checks, %0d errors",
      n_checks, n_errors);
    $finish;
  end

endmodule
